wb_ram_slave: RTL and testbench

//  Pipelined Wishbone B4 slave: word-addressed, byte-writable RAM; responder end of the dcache/icache WB master bus.

---
 rtl/wb_ram_slave_pkg.sv | 26 ++
 rtl/wb_ram_slave_resp_pipe.sv | 52 +++++
 rtl/wb_ram_slave.sv | 116 +++++++++++
 tb/tb_wb_ram_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_slave_pkg.sv
// Shared Wishbone types and helpers for the RAM slave and the cache masters.
// Bus request/response structs use the default 32-bit data path.
package sysnum_wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned SEL_DEFAULT  = XLEN_DEFAULT / 8;

    typedef struct packed {
        logic                    we;
        logic [XLEN_DEFAULT-1:0] addr;
        logic [XLEN_DEFAULT-1:0] data;
        logic [SEL_DEFAULT-1:0]  sel;
    } wb_req_t;

    typedef struct packed {
        logic                    ack;
        logic                    err;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_rsp_t;

    // Number of byte-offset address bits inside one bus word.
    function automatic int unsigned lane_bits(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/wb_ram_slave_resp_pipe.sv
// Fixed-depth response delay line for the Wishbone RAM slave.
// Flushing clears only the valid bits; payload bits are don't-care without valid.
module wb_resp_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 32
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic         i_is_read,
    input  logic         i_err,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_is_read,
    output logic         o_err,
    output logic [W-1:0] o_data
);

    logic         valid_q   [DEPTH];
    logic         is_read_q [DEPTH];
    logic         err_q     [DEPTH];
    logic [W-1:0] data_q    [DEPTH];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                is_read_q[i] <= 1'b0;
                err_q[i]     <= 1'b0;
                data_q[i]    <= '0;
            end
        end else begin
            valid_q[0]   <= i_valid & ~i_flush;
            is_read_q[0] <= i_is_read;
            err_q[0]     <= i_err;
            data_q[0]    <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i]   <= valid_q[i-1] & ~i_flush;
                is_read_q[i] <= is_read_q[i-1];
                err_q[i]     <= err_q[i-1];
                data_q[i]    <= data_q[i-1];
            end
        end
    end

    assign o_valid   = valid_q[DEPTH-1];
    assign o_is_read = is_read_q[DEPTH-1];
    assign o_err     = err_q[DEPTH-1];
    assign o_data    = data_q[DEPTH-1];

endmodule

// File: rtl/wb_ram_slave.sv
// Pipelined Wishbone B4 RAM slave: byte-writable word RAM, fixed-latency in-order
// ack/err responses and optional periodic stall injection.
module wb_ram_slave
    import sysnum_wb_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter int unsigned     MEM_WORDS    = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR    = '0,
    parameter int unsigned     LATENCY      = 1,
    parameter int unsigned     STALL_PERIOD = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [XLEN-1:0]   i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic [XLEN/8-1:0] i_wb_sel,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [XLEN-1:0]   o_wb_data
);

    localparam int unsigned SEL_W     = XLEN / 8;
    localparam int unsigned MEM_BITS  = $clog2(MEM_WORDS * SEL_W);
    localparam int unsigned LANE_BITS = lane_bits(XLEN);
    localparam int unsigned IDX_W     = MEM_BITS - LANE_BITS;

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [XLEN-1:0]  rd_word;
    logic             stall_q;
    logic             unused_lane_bits;

    logic [XLEN-1:0]  mem [MEM_WORDS];

    logic             p_valid;
    logic             p_is_read;
    logic             p_err;
    logic [XLEN-1:0]  p_data;

    assign accept   = i_wb_cyc & i_wb_stb & ~stall_q;
    assign in_range = (i_wb_addr[XLEN-1:MEM_BITS] == BASE_ADDR[XLEN-1:MEM_BITS]);
    assign word_idx = i_wb_addr[MEM_BITS-1:LANE_BITS];

    assign unused_lane_bits = ^i_wb_addr[LANE_BITS-1:0];

    // Read before the same-edge write; one request per cycle means a read
    // always observes every write accepted on an earlier edge.
    assign rd_word = (in_range && !i_wb_we) ? mem[word_idx] : '0;

    always_ff @(posedge i_clk) begin
        if (accept && in_range && i_wb_we) begin
            for (int unsigned b = 0; b < SEL_W; b++) begin
                if (i_wb_sel[b]) begin
                    mem[word_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int unsigned     CNT_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);

            logic [CNT_W-1:0] cnt_q;

            // Counter survives cyc aborts; only reset clears it.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    cnt_q   <= '0;
                    stall_q <= 1'b0;
                end else begin
                    stall_q <= 1'b0;
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            stall_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_stall
            assign stall_q = 1'b0;
        end
    endgenerate

    wb_resp_pipe #(
        .DEPTH (LATENCY),
        .W     (XLEN)
    ) u_resp_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (~i_wb_cyc),
        .i_valid   (accept),
        .i_is_read (~i_wb_we),
        .i_err     (~in_range),
        .i_data    (rd_word),
        .o_valid   (p_valid),
        .o_is_read (p_is_read),
        .o_err     (p_err),
        .o_data    (p_data)
    );

    assign o_wb_stall = stall_q;
    assign o_wb_ack   = p_valid & ~p_err;
    assign o_wb_err   = p_valid & p_err;
    assign o_wb_data  = (p_valid && p_is_read && !p_err) ? p_data : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three configurations driven from one directed sequence,
// with a scoreboard queue of expected responses checked by a negedge monitor.
module tb_wb_ram_slave;
    import sysnum_wb_pkg::*;

    typedef struct {
        wb_rsp_t rsp;
        int      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    int          dsel = 0;

    logic [2:0]  stall_v, ack_v, err_v;
    logic [31:0] rdata_v [3];

    int          lat [3] = '{1, 3, 1};
    int          cycle_cnt = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        sb [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    wb_ram_slave #(.XLEN(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .STALL_PERIOD(0)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc & (dsel == 0)), .i_wb_stb(stb & (dsel == 0)),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[0]), .o_wb_ack(ack_v[0]), .o_wb_err(err_v[0]), .o_wb_data(rdata_v[0]));

    wb_ram_slave #(.XLEN(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .STALL_PERIOD(0)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc & (dsel == 1)), .i_wb_stb(stb & (dsel == 1)),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[1]), .o_wb_ack(ack_v[1]), .o_wb_err(err_v[1]), .o_wb_data(rdata_v[1]));

    wb_ram_slave #(.XLEN(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .STALL_PERIOD(2)) u_dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc & (dsel == 2)), .i_wb_stb(stb & (dsel == 2)),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall_v[2]), .o_wb_ack(ack_v[2]), .o_wb_err(err_v[2]), .o_wb_data(rdata_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic wb_req_t req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_req_t r;
        r.we = w; r.addr = a; r.data = d; r.sel = s;
        return r;
    endfunction

    // Called while the request is on the bus in the cycle of its accept edge.
    task automatic push_expected(input wb_req_t r);
        exp_t e;
        int   key;
        key = dsel * 4096 + int'(r.addr[11:2]);
        e.rsp.ack  = 1'b0;
        e.rsp.err  = 1'b0;
        e.rsp.data = '0;
        if (r.addr[31:12] != 20'h0) begin
            e.rsp.err = 1'b1;
        end else begin
            e.rsp.ack = 1'b1;
            if (r.we) begin
                if (!model.exists(key)) model[key] = 'x;
                for (int b = 0; b < 4; b++)
                    if (r.sel[b]) model[key][8*b +: 8] = r.data[8*b +: 8];
            end else begin
                e.rsp.data = model[key];
            end
        end
        e.cyc = cycle_cnt + lat[dsel];
        sb.push_back(e);
    endtask

    task automatic issue(input wb_req_t r);
        int tries;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = r.we; addr = r.addr; wdata = r.data; sel = r.sel;
        tries = 0;
        while (stall_v[dsel] === 1'b1 && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        check("accept_bound", 32'(tries < 8), 32'd1);
        push_expected(r);
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        @(negedge clk);
        stb = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
            n++;
        end
        check({"drain_", tag}, 32'(sb.size()), 32'd0);
    endtask

    task automatic abort_cyc(output int dropped);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        dropped = 0;
        while (sb.size() > 0 && sb[$].cyc >= cycle_cnt) begin
            void'(sb.pop_back());
            dropped++;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && (ack_v[dsel] === 1'b1 || err_v[dsel] === 1'b1)) begin
            check("ack_err_excl", 32'(ack_v[dsel] & err_v[dsel]), 32'd0);
            check("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_ack", 32'(ack_v[dsel]), 32'(e.rsp.ack));
                check("rsp_err", 32'(err_v[dsel]), 32'(e.rsp.err));
                check("rsp_data", rdata_v[dsel], e.rsp.data);
                check("rsp_cycle", 32'(cycle_cnt), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         dropped;
        int         accepts;
        logic [5:0] exp_stall;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_stall", 32'(stall_v[i]), 32'd0);
            check("reset_ack", 32'(ack_v[i]), 32'd0);
            check("reset_err", 32'(err_v[i]), 32'd0);
            check("reset_data", rdata_v[i], 32'd0);
        end
        rst_n = 1'b1;

        // T1/T2/T4 on LATENCY=1
        dsel = 0;
        issue(req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
        issue(req(1'b0, 32'h10, 32'h0, 4'hF));
        issue(req(1'b1, 32'h20, 32'h11223344, 4'hF));
        issue(req(1'b1, 32'h20, 32'h000000AA, 4'b0001));
        issue(req(1'b0, 32'h20, 32'h0, 4'hF));
        issue(req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000));
        issue(req(1'b0, 32'h20, 32'h0, 4'hF));
        issue(req(1'b0, 32'h10, 32'h0, 4'hF));
        issue(req(1'b0, 32'h1000, 32'h0, 4'hF));
        issue(req(1'b0, 32'h20, 32'h0, 4'hF));
        issue(req(1'b1, 32'h1010, 32'h55555555, 4'hF));
        issue(req(1'b0, 32'h13, 32'h0, 4'hF));
        issue(req(1'b1, 32'hFFC, 32'hA5A5C3C3, 4'hF));
        issue(req(1'b0, 32'hFFC, 32'h0, 4'hF));
        drain("t1_t2_t4");

        // Reset in the middle of a burst
        issue(req(1'b1, 32'h24, 32'hCAFEF00D, 4'hF));
        issue(req(1'b0, 32'h24, 32'h0, 4'hF));
        issue(req(1'b0, 32'h20, 32'h0, 4'hF));
        stb = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack_v[0]), 32'd0);
        check("midrst_err", 32'(err_v[0]), 32'd0);
        check("midrst_data", rdata_v[0], 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(req(1'b0, 32'h24, 32'h0, 4'hF));
        drain("midrst");

        // T3: LATENCY=3 back-to-back reads
        dsel = 1;
        for (int i = 0; i < 4; i++)
            issue(req(1'b1, 32'(i * 4), 32'h0BAD0000 + 32'(i), 4'hF));
        for (int i = 0; i < 4; i++)
            issue(req(1'b0, 32'(i * 4), 32'h0, 4'hF));
        drain("t3");

        // T6: abort with two reads in flight, then with a write in flight
        issue(req(1'b1, 32'h30, 32'h30303030, 4'hF));
        drain("t6_write");
        issue(req(1'b0, 32'h0, 32'h0, 4'hF));
        issue(req(1'b0, 32'h4, 32'h0, 4'hF));
        abort_cyc(dropped);
        check("t6_dropped_reads", 32'(dropped), 32'd2);
        repeat (6) @(negedge clk);
        cyc = 1'b1;
        repeat (4) @(negedge clk);
        issue(req(1'b1, 32'h34, 32'h34343434, 4'hF));
        abort_cyc(dropped);
        check("t6_dropped_write", 32'(dropped), 32'd1);
        repeat (4) @(negedge clk);
        issue(req(1'b0, 32'h30, 32'h0, 4'hF));
        issue(req(1'b0, 32'h34, 32'h0, 4'hF));
        drain("t6");

        // T5: STALL_PERIOD=2 with stb held for six cycles
        dsel = 2;
        issue(req(1'b1, 32'h40, 32'hA1A1A1A1, 4'hF));
        issue(req(1'b1, 32'h44, 32'hA2A2A2A2, 4'hF));
        drain("t5_setup");
        exp_stall = 6'b100100;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h40; sel = 4'hF;
            check($sformatf("t5_stall_c%0d", i), 32'(stall_v[2]), 32'(exp_stall[i]));
            if (stall_v[2] === 1'b0) begin
                accepts++;
                push_expected(req(1'b0, 32'h40, 32'h0, 4'hF));
            end
        end
        @(posedge clk);
        check("t5_accepts", 32'(accepts), 32'd4);
        drain("t5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
